// File: rtl/core_div_pkg.sv
// Shared definitions for the iterative radix-2 restoring divider.
// Contents: control encodings (DIV/DIVU/REM/REMU and W aliases), the
// sequencer state enum, and the iteration-counter width helper.
package core_div_pkg;

    // i_control encodings; bit 1 selects remainder, bit 0 selects unsigned
    localparam logic [1:0] CTL_DIV   = 2'b00;
    localparam logic [1:0] CTL_DIVU  = 2'b01;
    localparam logic [1:0] CTL_REM   = 2'b10;
    localparam logic [1:0] CTL_REMU  = 2'b11;

    // W forms share the encoding; i_isword distinguishes them
    localparam logic [1:0] CTL_DIVW  = CTL_DIV;
    localparam logic [1:0] CTL_DIVUW = CTL_DIVU;
    localparam logic [1:0] CTL_REMW  = CTL_REM;
    localparam logic [1:0] CTL_REMUW = CTL_REMU;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } div_state_t;

    // Counter must hold the value XLEN itself
    function automatic int unsigned cnt_width(input int unsigned xlen);
        return $clog2(xlen + 1);
    endfunction

endpackage

// File: rtl/core_div_step.sv
// One restoring shift-subtract iteration (combinational).
// Ports:
//   i_rem  partial remainder (always < divisor)
//   i_quo  dividend/quotient shift register; MSB is the next dividend bit
//   i_div  divisor magnitude
//   o_rem  next partial remainder
//   o_quo  next quotient register, new quotient bit shifted in at LSB
module core_div_step #(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_div,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0]   w_shift;
    logic [XLEN-1:0] w_sub;
    logic            w_ge;

    assign w_shift = {i_rem, i_quo[XLEN-1]};
    assign w_ge    = (w_shift >= {1'b0, i_div});
    // When w_ge holds the true difference is < i_div, so the low XLEN bits are exact
    assign w_sub   = w_shift[XLEN-1:0] - i_div;

    assign o_rem = w_ge ? w_sub : w_shift[XLEN-1:0];
    assign o_quo = {i_quo[XLEN-2:0], w_ge};

endmodule

// File: rtl/core_div_ctrl.sv
// Sequencer for the iterative radix-2 restoring divider (RV64M DIV/DIVU/REM/REMU
// and W forms): operand conditioning, iteration, sign fix-up, W sign-extension
// and the divide-by-zero / signed-overflow special cases.
// Optional build macro: CORE_DIV_EARLY_OUT_EN skips iteration when |a| < |b|.
// Ports:
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_flush             abort any op in flight
//   i_req_valid/o_req_ready   issue handshake; i_srcA, i_srcB, i_control, i_isword payload
//   o_res_valid/i_res_ready   writeback handshake; o_result payload
//   o_busy              state other than IDLE
module core_div_ctrl
    import core_div_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic [XLEN-1:0] i_srcA,
    input  logic [XLEN-1:0] i_srcB,
    input  logic [1:0]      i_control,
    input  logic            i_isword,
    output logic            o_res_valid,
    input  logic            i_res_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy
);

    localparam int unsigned HALF  = XLEN / 2;
    localparam int unsigned CNT_W = cnt_width(XLEN);

    div_state_t      r_state, w_state_nxt;
    logic [XLEN-1:0] r_a, r_b;
    logic [1:0]      r_ctl;
    logic            r_isword;
    logic [XLEN-1:0] r_rem, r_quo, r_div;
    logic [CNT_W-1:0] r_cnt;
    logic            r_q_neg, r_r_neg;
    logic [XLEN-1:0] r_result;
    logic            r_res_valid, r_busy, r_req_ready;

    logic            w_accept, w_signed;
    logic [XLEN-1:0] w_a_ext, w_b_ext, w_abs_a, w_abs_b, w_min;
    logic            w_a_neg, w_b_neg, w_div_zero, w_ovf, w_special, w_early;
    logic [XLEN-1:0] w_step_rem, w_step_quo, w_q_fix, w_r_fix, w_sel;
    logic [CNT_W-1:0] w_n;

    // Narrow a result to the W width when required
    function automatic logic [XLEN-1:0] fmt_res(input logic [XLEN-1:0] v, input logic w);
        return w ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
    endfunction

    assign w_accept = i_req_valid & r_req_ready & ~i_flush;
    assign w_signed = ~r_ctl[0];

    // Operand conditioning: extend W operands, then take magnitudes for signed ops
    assign w_a_ext = r_isword ? (w_signed ? {{HALF{r_a[HALF-1]}}, r_a[HALF-1:0]}
                                          : {{HALF{1'b0}}, r_a[HALF-1:0]}) : r_a;
    assign w_b_ext = r_isword ? (w_signed ? {{HALF{r_b[HALF-1]}}, r_b[HALF-1:0]}
                                          : {{HALF{1'b0}}, r_b[HALF-1:0]}) : r_b;
    assign w_a_neg = w_signed & w_a_ext[XLEN-1];
    assign w_b_neg = w_signed & w_b_ext[XLEN-1];
    assign w_abs_a = w_a_neg ? -w_a_ext : w_a_ext;
    assign w_abs_b = w_b_neg ? -w_b_ext : w_b_ext;

    // Most-negative value at the operating width, as seen after extension
    assign w_min      = r_isword ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}}
                                 : {1'b1, {(XLEN-1){1'b0}}};
    assign w_div_zero = (w_b_ext == '0);
    assign w_ovf      = w_signed & (w_b_ext == '1) & (w_a_ext == w_min);
    assign w_special  = w_div_zero | w_ovf;
    assign w_n        = r_isword ? CNT_W'(HALF) : CNT_W'(XLEN);

`ifdef CORE_DIV_EARLY_OUT_EN
    assign w_early = (w_abs_a < w_abs_b);
`else
    assign w_early = 1'b0;
`endif

    core_div_step #(.XLEN(XLEN)) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_step_rem),
        .o_quo (w_step_quo)
    );

    // Sign fix-up and result selection
    assign w_q_fix = r_q_neg ? -r_quo : r_quo;
    assign w_r_fix = r_r_neg ? -r_rem : r_rem;
    assign w_sel   = r_ctl[1] ? w_r_fix : w_q_fix;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: if (i_req_valid) w_state_nxt = PREP;
                PREP: begin
                    if (w_special)    w_state_nxt = DONE;
                    else if (w_early) w_state_nxt = FIX;
                    else              w_state_nxt = CALC;
                end
                CALC: if (r_cnt == CNT_W'(1)) w_state_nxt = FIX;
                FIX:  w_state_nxt = DONE;
                DONE: if (i_res_ready) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Handshake/status outputs registered from the next state
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_req_ready <= 1'b1;
        end else begin
            r_res_valid <= (w_state_nxt == DONE);
            r_busy      <= (w_state_nxt != IDLE);
            r_req_ready <= (w_state_nxt == IDLE);
        end
    end

    // Operand capture, iteration datapath and result register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_ctl    <= '0;
            r_isword <= 1'b0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_a      <= i_srcA;
                r_b      <= i_srcB;
                r_ctl    <= i_control;
                r_isword <= i_isword;
            end
            case (r_state)
                PREP: begin
                    r_q_neg <= w_a_neg ^ w_b_neg;
                    r_r_neg <= w_a_neg;
                    r_div   <= w_abs_b;
                    r_cnt   <= w_n;
                    if (w_early) begin
                        r_rem <= w_abs_a;
                        r_quo <= '0;
                    end else begin
                        r_rem <= '0;
                        // W dividend is aligned to the MSB so iteration starts at bit HALF-1
                        r_quo <= r_isword ? (w_abs_a << HALF) : w_abs_a;
                    end
                    if (w_div_zero)
                        r_result <= fmt_res(r_ctl[1] ? w_a_ext : '1, r_isword);
                    else if (w_ovf)
                        r_result <= fmt_res(r_ctl[1] ? '0 : w_a_ext, r_isword);
                end
                CALC: begin
                    r_rem <= w_step_rem;
                    r_quo <= w_step_quo;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                FIX: r_result <= fmt_res(w_sel, r_isword);
                default: ;
            endcase
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_res_valid = r_res_valid;
    assign o_busy      = r_busy;
    assign o_result    = r_result;

endmodule

// File: tb/tb_core_div_ctrl.sv
// Self-checking bench for core_div_ctrl (XLEN=64). Expected results and
// latencies come from an arithmetic reference model and are queued when an
// op is issued, then popped and compared when o_res_valid rises.
module tb_core_div_ctrl;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] src_a, src_b;
    logic [1:0]  ctl;
    logic        isword;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] result;
    logic        busy;

    int n_vec;
    int n_err;

    logic [63:0] exp_q[$];
    int          exp_lat_q[$];

    core_div_ctrl #(.XLEN(64)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_flush     (flush),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_srcA      (src_a),
        .i_srcB      (src_b),
        .i_control   (ctl),
        .i_isword    (isword),
        .o_res_valid (res_valid),
        .i_res_ready (res_ready),
        .o_result    (result),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: RISC-V division semantics plus expected latency
    function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] c, input logic w, output int lat);
        logic        sgn, rem;
        logic [31:0] a32, b32, r32, ua32, ub32;
        logic [63:0] r64, ua64, ub64;
        sgn = ~c[0];
        rem = c[1];
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            lat = 35;
            if (b32 == 32'd0) begin
                r32 = rem ? a32 : 32'hFFFF_FFFF;
                lat = 2;
            end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                r32 = rem ? 32'd0 : a32;
                lat = 2;
            end else begin
                if (sgn && rem)       r32 = $signed(a32) % $signed(b32);
                else if (sgn)         r32 = $signed(a32) / $signed(b32);
                else if (rem)         r32 = a32 % b32;
                else                  r32 = a32 / b32;
                ua32 = (sgn && a32[31]) ? -a32 : a32;
                ub32 = (sgn && b32[31]) ? -b32 : b32;
`ifdef CORE_DIV_EARLY_OUT_EN
                if (ua32 < ub32) lat = 3;
`endif
            end
            return {{32{r32[31]}}, r32};
        end else begin
            lat = 67;
            if (b == 64'd0) begin
                r64 = rem ? a : 64'hFFFF_FFFF_FFFF_FFFF;
                lat = 2;
            end else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
                r64 = rem ? 64'd0 : a;
                lat = 2;
            end else begin
                if (sgn && rem)       r64 = $signed(a) % $signed(b);
                else if (sgn)         r64 = $signed(a) / $signed(b);
                else if (rem)         r64 = a % b;
                else                  r64 = a / b;
                ua64 = (sgn && a[63]) ? -a : a;
                ub64 = (sgn && b[63]) ? -b : b;
`ifdef CORE_DIV_EARLY_OUT_EN
                if (ua64 < ub64) lat = 3;
`endif
            end
            return r64;
        end
    endfunction

    // Issue one op, queue its expectation, wait (bounded) for the result
    task automatic issue_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] c,
                            input logic w, output logic [63:0] obs, output int lat,
                            output logic tmo);
        int          guard;
        int          l_exp;
        logic [63:0] e;
        e = model(a, b, c, w, l_exp);
        exp_q.push_back(e);
        exp_lat_q.push_back(l_exp);
        guard = 0;
        obs   = '0;
        lat   = 0;
        tmo   = 1'b0;
        @(negedge clk);
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            tmo = 1'b1;
            return;
        end
        src_a = a; src_b = b; ctl = c; isword = w; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        while (lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (res_valid) break;
        end
        tmo = !res_valid;
        obs = result;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid got %0b want 0", res_valid); end
        n_vec++; if (result !== 64'd0) begin n_err++; $display("FAIL reset_result got %h want 0", result); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %0b want 1", req_ready); end
        @(negedge clk) rst_n = 1'b1;
    endtask

    // Directed ops: result and latency checked for each table entry
    task automatic test_directed;
        logic [63:0] ta[11], tb[11];
        logic [1:0]  tc[11];
        logic        tw[11];
        logic [63:0] obs, e;
        int          lat, le;
        logic        tmo;
        ta[0]  = -64'sd7;                 tb[0]  = 64'd2;  tc[0]  = 2'b00; tw[0]  = 1'b0;
        ta[1]  = -64'sd7;                 tb[1]  = 64'd2;  tc[1]  = 2'b10; tw[1]  = 1'b0;
        ta[2]  = 64'd100;                 tb[2]  = 64'd7;  tc[2]  = 2'b11; tw[2]  = 1'b0;
        ta[3]  = 64'hFFFF_FFFF_FFFF_FFFF; tb[3]  = 64'd1;  tc[3]  = 2'b01; tw[3]  = 1'b0;
        ta[4]  = 64'd5;                   tb[4]  = 64'd0;  tc[4]  = 2'b00; tw[4]  = 1'b0;
        ta[5]  = 64'd5;                   tb[5]  = 64'd0;  tc[5]  = 2'b10; tw[5]  = 1'b0;
        ta[6]  = 64'h8000_0000_0000_0000; tb[6]  = 64'hFFFF_FFFF_FFFF_FFFF; tc[6] = 2'b00; tw[6] = 1'b0;
        ta[7]  = 64'h8000_0000_0000_0000; tb[7]  = 64'hFFFF_FFFF_FFFF_FFFF; tc[7] = 2'b10; tw[7] = 1'b0;
        ta[8]  = 64'h0000_0000_8000_0000; tb[8]  = 64'h0000_0000_FFFF_FFFF; tc[8] = 2'b00; tw[8] = 1'b1;
        ta[9]  = 64'h1234_5678_8000_0000; tb[9]  = 64'd2;  tc[9]  = 2'b00; tw[9]  = 1'b1;
        ta[10] = 64'h1234_5678_8000_0000; tb[10] = 64'd2;  tc[10] = 2'b01; tw[10] = 1'b1;
        for (int i = 0; i < 11; i++) begin
            issue_op(ta[i], tb[i], tc[i], tw[i], obs, lat, tmo);
            e  = exp_q.pop_front();
            le = exp_lat_q.pop_front();
            n_vec++;
            if (tmo || obs !== e) begin
                n_err++;
                $display("FAIL directed[%0d] result got %h want %h timeout=%0b", i, obs, e, tmo);
            end
            n_vec++;
            if (lat !== le) begin
                n_err++;
                $display("FAIL directed[%0d] latency got %0d want %0d", i, lat, le);
            end
        end
    endtask

    // Hard-coded spot values independent of the model
    task automatic test_known_values;
        logic [63:0] obs, e;
        int          lat, le;
        logic        tmo;
        issue_op(-64'sd7, 64'd2, 2'b00, 1'b0, obs, lat, tmo);
        e = exp_q.pop_front(); le = exp_lat_q.pop_front();
        n_vec++; if (obs !== 64'hFFFF_FFFF_FFFF_FFFD || lat != 67) begin n_err++; $display("FAIL div_m7_2 got %h lat %0d want fffffffffffffffd lat 67", obs, lat); end
        issue_op(64'h1234_5678_8000_0000, 64'd2, 2'b00, 1'b1, obs, lat, tmo);
        e = exp_q.pop_front(); le = exp_lat_q.pop_front();
        n_vec++; if (obs !== 64'hFFFF_FFFF_C000_0000 || lat != 35) begin n_err++; $display("FAIL divw_known got %h lat %0d want ffffffffc0000000 lat 35", obs, lat); end
        issue_op(64'd5, 64'd0, 2'b10, 1'b0, obs, lat, tmo);
        e = exp_q.pop_front(); le = exp_lat_q.pop_front();
        n_vec++; if (obs !== 64'd5 || lat != 2) begin n_err++; $display("FAIL rem_by_zero got %h lat %0d want 5 lat 2", obs, lat); end
    endtask

    task automatic test_random;
        logic [63:0] a, b, obs, e;
        logic [1:0]  c;
        logic        w, tmo;
        int          lat, le;
        for (int i = 0; i < 14; i++) begin
            a = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: b = 64'($urandom_range(1, 20));
                1: b = {$urandom, $urandom};
                2: b = 64'd0;
                default: b = -64'($urandom_range(1, 20));
            endcase
            c = 2'($urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            issue_op(a, b, c, w, obs, lat, tmo);
            e  = exp_q.pop_front();
            le = exp_lat_q.pop_front();
            n_vec++;
            if (tmo || obs !== e || lat !== le) begin
                n_err++;
                $display("FAIL random[%0d] a=%h b=%h c=%0d w=%0b got %h lat %0d want %h lat %0d", i, a, b, c, w, obs, lat, e, le);
            end
        end
    endtask

    task automatic test_flush;
        logic        saw_valid;
        logic [63:0] obs, e;
        int          lat, le;
        logic        tmo;
        @(negedge clk);
        src_a = 64'hFFFF_0000_1234_5678; src_b = 64'd3; ctl = 2'b01; isword = 1'b0; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        n_vec++; if (busy !== 1'b0 || req_ready !== 1'b1 || res_valid !== 1'b0) begin n_err++; $display("FAIL flush_idle busy %0b ready %0b valid %0b want 0 1 0", busy, req_ready, res_valid); end
        saw_valid = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            if (res_valid) saw_valid = 1'b1;
        end
        n_vec++; if (saw_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_result got valid %0b want 0", saw_valid); end
        // Flush in the same cycle as a request: the request must not be taken
        @(negedge clk);
        src_a = 64'd9; src_b = 64'd3; ctl = 2'b01; req_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0; flush = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_beats_accept busy got %0b want 0", busy); end
        issue_op(64'd9, 64'd3, 2'b01, 1'b0, obs, lat, tmo);
        e = exp_q.pop_front(); le = exp_lat_q.pop_front();
        n_vec++; if (tmo || obs !== 64'd3 || lat !== le) begin n_err++; $display("FAIL after_flush_divu got %h lat %0d want 3 lat %0d", obs, lat, le); end
        // Reset mid-operation discards the op
        @(negedge clk);
        src_a = 64'd1000; src_b = 64'd7; ctl = 2'b00; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b0 || res_valid !== 1'b0 || result !== 64'd0 || req_ready !== 1'b1) begin n_err++; $display("FAIL midop_reset busy %0b valid %0b result %h ready %0b", busy, res_valid, result, req_ready); end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_backpressure;
        logic [63:0] obs, e;
        int          lat, le;
        logic        tmo;
        res_ready = 1'b0;
        issue_op(64'd1000, 64'd7, 2'b01, 1'b0, obs, lat, tmo);
        e = exp_q.pop_front(); le = exp_lat_q.pop_front();
        n_vec++; if (tmo || obs !== e) begin n_err++; $display("FAIL bp_first got %h want %h", obs, e); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            src_a = 64'd50; src_b = 64'd5; ctl = 2'b01; req_valid = 1'b1;
            @(posedge clk); #1;
            n_vec++;
            if (res_valid !== 1'b1 || result !== e || req_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold[%0d] valid %0b result %h ready %0b want 1 %h 0", i, res_valid, result, req_ready, e);
            end
        end
        @(negedge clk);
        req_valid = 1'b0; res_ready = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (res_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL bp_release valid %0b ready %0b busy %0b want 0 1 0", res_valid, req_ready, busy); end
        @(posedge clk); #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_no_accept busy got %0b want 0", busy); end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; res_ready = 1'b1;
        src_a = '0; src_b = '0; ctl = '0; isword = 1'b0;
        test_reset();
        test_directed();
        test_known_values();
        test_random();
        test_flush();
        test_backpressure();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
